// File: rtl/skein_pkg.sv
// Shared constants and types for the Skein-1024 core sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state type, registered control bundle, Threefish-1024 rotation
// table, inverse word permutation, x1 mux encodings and word-count constants.
package skein_pkg;

  localparam int NUM_WORDS = 16;
  localparam int NUM_PAIRS = 8;

  localparam logic [3:0] LAST_WORD      = 4'(NUM_WORDS - 1);
  localparam logic [3:0] LAST_PAIR      = 4'(NUM_PAIRS - 1);
  // Words 13..15 take a key-schedule cycle before their injection cycle.
  localparam logic [3:0] INJ_SPLIT_WORD = 4'd13;

  localparam logic [1:0] X1_STATE  = 2'd0;
  localparam logic [1:0] X1_TWEAK  = 2'd1;
  localparam logic [1:0] X1_SUBKEY = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INJ,
    ST_COPY,
    ST_MIX,
    ST_FF,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        input_register_write;
    logic [3:0]  word;
    logic        x0_key_select;
    logic [1:0]  x1_sel;
    logic [63:0] tweak_word;
    logic [5:0]  rotate_constant;
    logic [15:0] y1_select;
    logic [15:0] output_register_write;
    logic        key_register_write;
    logic        hash_mode;
    logic        subkey_write;
    logic        plaintext_select;
    logic [4:0]  subkey;
    logic        hash_register_write;
  } ctl_t;

  // Threefish-1024 MIX rotation constants, indexed [round mod 8][pair].
  localparam logic [5:0] R1024 [8][8] = '{
    '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
    '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
    '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
    '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
    '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
    '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
    '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
    '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
  };

  // Inverse word permutation: MIX output word j lands in register PINV[j].
  localparam logic [3:0] PINV [16] = '{
    4'd0, 4'd15, 4'd2, 4'd11, 4'd6, 4'd13, 4'd4, 4'd9,
    4'd14, 4'd1, 4'd8, 4'd5, 4'd10, 4'd3, 4'd12, 4'd7
  };

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/skein_core_sequencer_if.sv
// Control bundle between the Skein-1024 sequencer and the serial core datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the core consumes every control cycle.
// master = sequencer (drives controls, receives start); slave = core side.
interface skein_core_sequencer_if;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        input_register_write_o;
  logic [3:0]  word_o;
  logic        x0_key_select_o;
  logic [1:0]  x1_tweak_subkey_select_o;
  logic [63:0] tweak_word_o;
  logic [5:0]  rotate_constant_o;
  logic [15:0] Y1_select_o;
  logic [15:0] output_register_write_o;
  logic        key_register_write_o;
  logic        hash_mode_o;
  logic        subkey_write_o;
  logic        output_register_plaintext_select_o;
  logic [4:0]  subkey_o;
  logic        hash_register_write_o;

  modport master (
    input  start_i,
    output busy_o, done_o, input_register_write_o, word_o, x0_key_select_o,
           x1_tweak_subkey_select_o, tweak_word_o, rotate_constant_o, Y1_select_o,
           output_register_write_o, key_register_write_o, hash_mode_o, subkey_write_o,
           output_register_plaintext_select_o, subkey_o, hash_register_write_o
  );

  modport slave (
    output start_i,
    input  busy_o, done_o, input_register_write_o, word_o, x0_key_select_o,
           x1_tweak_subkey_select_o, tweak_word_o, rotate_constant_o, Y1_select_o,
           output_register_write_o, key_register_write_o, hash_mode_o, subkey_write_o,
           output_register_plaintext_select_o, subkey_o, hash_register_write_o
  );
endinterface

// File: rtl/skein_tweak_gen.sv
// Tweak word for the key-schedule cycles of words 13/14/15 of an injection.
// Latency: combinational.
// Backpressure: none.
// Ports: hash_mode (0 = message block, 1 = output block), s (subkey index),
// w (word index), tweak_word (t[s mod 3], t[(s+1) mod 3] or zero-extended s).
module skein_tweak_gen
  import skein_pkg::*;
#(
  parameter logic [63:0] TWEAK_MSG_T0 = 64'd32,
  parameter logic [63:0] TWEAK_MSG_T1 = 64'hF000_0000_0000_0000,
  parameter logic [63:0] TWEAK_OUT_T0 = 64'd8,
  parameter logic [63:0] TWEAK_OUT_T1 = 64'hFF00_0000_0000_0000
) (
  input  logic        hash_mode,
  input  logic [4:0]  s,
  input  logic [3:0]  w,
  output logic [63:0] tweak_word
);
  logic [63:0] t0, t1;
  logic [1:0]  idx_a, idx_b;

  function automatic logic [63:0] pick(input logic [1:0] i, input logic [63:0] a,
                                       input logic [63:0] b);
    case (i)
      2'd0:    return a;
      2'd1:    return b;
      default: return a ^ b;  // t2 is the xor of the two stored words
    endcase
  endfunction

  always_comb begin
    t0         = hash_mode ? TWEAK_OUT_T0 : TWEAK_MSG_T0;
    t1         = hash_mode ? TWEAK_OUT_T1 : TWEAK_MSG_T1;
    idx_a      = 2'(s % 5'd3);
    idx_b      = (idx_a == 2'd2) ? 2'd0 : idx_a + 2'd1;
    tweak_word = '0;
    if (w == INJ_SPLIT_WORD)              tweak_word = pick(idx_a, t0, t1);
    else if (w == INJ_SPLIT_WORD + 4'd1)  tweak_word = pick(idx_b, t0, t1);
    else if (w == LAST_WORD)              tweak_word = {59'b0, s};
  end
endmodule

// File: rtl/skein_core_sequencer.sv
// Control FSM for the serial Skein-1024 core: one start runs two UBI blocks.
// Latency: 2283 cycles start->done at ROUNDS=80; all outputs registered.
// Backpressure: none; start is ignored while a hash is in flight.
// Ports: clk_i, rst_n_i (async active-low), ctl (master side of the control bundle).
module skein_core_sequencer
  import skein_pkg::*;
#(
  parameter int          ROUNDS       = 80,
  parameter logic [63:0] TWEAK_MSG_T0 = 64'd32,
  parameter logic [63:0] TWEAK_MSG_T1 = 64'hF000_0000_0000_0000,
  parameter logic [63:0] TWEAK_OUT_T0 = 64'd8,
  parameter logic [63:0] TWEAK_OUT_T1 = 64'hFF00_0000_0000_0000
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  skein_core_sequencer_if.master ctl
);
  localparam logic [4:0] S_LAST = 5'(ROUNDS / 4);

  seq_state_t  state, nxt_state;
  logic        mode, nxt_mode;
  logic [4:0]  s, nxt_s;
  logic [2:0]  d, nxt_d;            // round number mod 8 selects the rotation row
  logic [3:0]  w, nxt_w;            // word index in INJ, pair index in MIX
  logic        ph, nxt_ph;          // 0 = key-schedule cycle of words 13..15
  logic        copy_to_inj, nxt_copy_to_inj;
  logic [63:0] tweak;
  ctl_t        ctl_nxt, ctl_q;

  skein_tweak_gen #(
    .TWEAK_MSG_T0(TWEAK_MSG_T0), .TWEAK_MSG_T1(TWEAK_MSG_T1),
    .TWEAK_OUT_T0(TWEAK_OUT_T0), .TWEAK_OUT_T1(TWEAK_OUT_T1)
  ) u_tweak (
    .hash_mode(nxt_mode), .s(nxt_s), .w(nxt_w), .tweak_word(tweak)
  );

  always_comb begin
    nxt_state       = state;
    nxt_mode        = mode;
    nxt_s           = s;
    nxt_d           = d;
    nxt_w           = w;
    nxt_ph          = 1'b0;
    nxt_copy_to_inj = copy_to_inj;
    case (state)
      ST_IDLE: if (ctl.start_i) begin
        nxt_state = ST_LOAD;
        nxt_mode  = 1'b0;
        nxt_s     = '0;
        nxt_d     = '0;
      end
      ST_LOAD: begin
        nxt_state = ST_INJ;
        nxt_w     = '0;
      end
      ST_INJ: begin
        if (w >= INJ_SPLIT_WORD && !ph) begin
          nxt_ph = 1'b1;
        end else if (w == LAST_WORD) begin
          nxt_w           = '0;
          nxt_copy_to_inj = 1'b0;
          nxt_state       = (s == S_LAST) ? ST_FF : ST_COPY;
        end else begin
          nxt_w = w + 4'd1;
        end
      end
      ST_COPY: begin
        nxt_w     = '0;
        nxt_state = copy_to_inj ? ST_INJ : ST_MIX;
        if (copy_to_inj) nxt_s = s + 5'd1;
      end
      ST_MIX: begin
        if (w == LAST_PAIR) begin
          nxt_state       = ST_COPY;
          nxt_w           = '0;
          nxt_d           = d + 3'd1;
          // Fourth round of the group: the following COPY hands over to INJ.
          nxt_copy_to_inj = (d[1:0] == 2'd3);
        end else begin
          nxt_w = w + 4'd1;
        end
      end
      ST_FF: begin
        if (!mode) begin
          nxt_state = ST_LOAD;
          nxt_mode  = 1'b1;
          nxt_s     = '0;
          nxt_d     = '0;
        end else begin
          nxt_state = ST_DONE;
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    ctl_nxt        = '0;
    ctl_nxt.x1_sel = X1_STATE;
    if (nxt_state != ST_IDLE && nxt_state != ST_DONE) begin
      ctl_nxt.busy      = 1'b1;
      ctl_nxt.hash_mode = nxt_mode;
    end
    case (nxt_state)
      ST_LOAD: begin
        ctl_nxt.input_register_write = 1'b1;
        ctl_nxt.plaintext_select     = 1'b1;
      end
      ST_INJ: begin
        ctl_nxt.word   = nxt_w;
        ctl_nxt.subkey = nxt_s;
        if (nxt_w >= INJ_SPLIT_WORD && !nxt_ph) begin
          ctl_nxt.x0_key_select = 1'b1;
          ctl_nxt.x1_sel        = X1_TWEAK;
          ctl_nxt.subkey_write  = 1'b1;
          ctl_nxt.tweak_word    = tweak;
        end else begin
          ctl_nxt.x1_sel                = X1_SUBKEY;
          ctl_nxt.output_register_write = onehot16(nxt_w);
        end
      end
      ST_COPY: ctl_nxt.input_register_write = 1'b1;
      ST_MIX: begin
        ctl_nxt.word                  = nxt_w;
        ctl_nxt.rotate_constant       = R1024[nxt_d][nxt_w[2:0]];
        ctl_nxt.output_register_write = onehot16(PINV[{nxt_w[2:0], 1'b0}])
                                      | onehot16(PINV[{nxt_w[2:0], 1'b1}]);
        ctl_nxt.y1_select             = onehot16(PINV[{nxt_w[2:0], 1'b1}]);
      end
      ST_FF: begin
        ctl_nxt.key_register_write  = !nxt_mode;
        ctl_nxt.hash_register_write = nxt_mode;
      end
      ST_DONE: ctl_nxt.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      mode        <= 1'b0;
      s           <= '0;
      d           <= '0;
      w           <= '0;
      ph          <= 1'b0;
      copy_to_inj <= 1'b0;
      ctl_q       <= '0;
    end else begin
      state       <= nxt_state;
      mode        <= nxt_mode;
      s           <= nxt_s;
      d           <= nxt_d;
      w           <= nxt_w;
      ph          <= nxt_ph;
      copy_to_inj <= nxt_copy_to_inj;
      ctl_q       <= ctl_nxt;
    end
  end

  assign ctl.busy_o                             = ctl_q.busy;
  assign ctl.done_o                             = ctl_q.done;
  assign ctl.input_register_write_o             = ctl_q.input_register_write;
  assign ctl.word_o                             = ctl_q.word;
  assign ctl.x0_key_select_o                    = ctl_q.x0_key_select;
  assign ctl.x1_tweak_subkey_select_o           = ctl_q.x1_sel;
  assign ctl.tweak_word_o                       = ctl_q.tweak_word;
  assign ctl.rotate_constant_o                  = ctl_q.rotate_constant;
  assign ctl.Y1_select_o                        = ctl_q.y1_select;
  assign ctl.output_register_write_o            = ctl_q.output_register_write;
  assign ctl.key_register_write_o               = ctl_q.key_register_write;
  assign ctl.hash_mode_o                        = ctl_q.hash_mode;
  assign ctl.subkey_write_o                     = ctl_q.subkey_write;
  assign ctl.output_register_plaintext_select_o = ctl_q.plaintext_select;
  assign ctl.subkey_o                           = ctl_q.subkey;
  assign ctl.hash_register_write_o              = ctl_q.hash_register_write;
endmodule

// File: tb/tb_skein_core_sequencer.sv
// Bench for skein_core_sequencer: expected control trace built from the block schedule.
module tb_skein_core_sequencer;
  localparam int          ROUNDS = 80;
  localparam int          NS     = ROUNDS / 4 + 1;
  localparam logic [63:0] MSG_T0 = 64'd32;
  localparam logic [63:0] MSG_T1 = 64'hF000_0000_0000_0000;
  localparam logic [63:0] OUT_T0 = 64'd8;
  localparam logic [63:0] OUT_T1 = 64'hFF00_0000_0000_0000;
  localparam int          IDLE_TAIL = 6;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        irw;
    logic [3:0]  word;
    logic        x0;
    logic [1:0]  x1;
    logic [63:0] tw;
    logic [5:0]  rot;
    logic [15:0] y1;
    logic [15:0] orw;
    logic        krw;
    logic        hm;
    logic        skw;
    logic        pts;
    logic [4:0]  sub;
    logic        hrw;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  skein_core_sequencer_if bus();

  skein_core_sequencer #(
    .ROUNDS(ROUNDS), .TWEAK_MSG_T0(MSG_T0), .TWEAK_MSG_T1(MSG_T1),
    .TWEAK_OUT_T0(OUT_T0), .TWEAK_OUT_T1(OUT_T1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ctl(bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  rec_t exp_q[$];
  int   mix_cnt;
  int   mix_blk0;

  // Forward Skein-1024 permutation: new word i takes old word perm[i].
  logic [3:0] perm [16] = '{4'd0, 4'd9, 4'd2, 4'd13, 4'd6, 4'd11, 4'd4, 4'd15,
                            4'd10, 4'd7, 4'd12, 4'd3, 4'd14, 4'd5, 4'd8, 4'd1};
  logic [3:0] pinv [16];
  logic [5:0] rot_tab [8][8] = '{
    '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
    '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
    '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
    '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
    '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
    '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
    '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
    '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
  };

  function automatic rec_t sample();
    rec_t r;
    r.busy = bus.busy_o;                   r.done = bus.done_o;
    r.irw  = bus.input_register_write_o;   r.word = bus.word_o;
    r.x0   = bus.x0_key_select_o;          r.x1   = bus.x1_tweak_subkey_select_o;
    r.tw   = bus.tweak_word_o;             r.rot  = bus.rotate_constant_o;
    r.y1   = bus.Y1_select_o;              r.orw  = bus.output_register_write_o;
    r.krw  = bus.key_register_write_o;     r.hm   = bus.hash_mode_o;
    r.skw  = bus.subkey_write_o;           r.pts  = bus.output_register_plaintext_select_o;
    r.sub  = bus.subkey_o;                 r.hrw  = bus.hash_register_write_o;
    return r;
  endfunction

  task automatic check_rec(input string name, input rec_t got, input rec_t req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [63:0] exp_tweak(input bit mode, input int s, input int w);
    logic [63:0] t [3];
    t[0] = mode ? OUT_T0 : MSG_T0;
    t[1] = mode ? OUT_T1 : MSG_T1;
    t[2] = t[0] ^ t[1];
    if (w == 13) return t[s % 3];
    if (w == 14) return t[(s + 1) % 3];
    return 64'(s);
  endfunction

  function automatic rec_t active(input bit mode);
    rec_t r = '0;
    r.busy = 1'b1;
    r.hm   = mode;
    return r;
  endfunction

  // One UBI block: LOAD, then per subkey an injection followed by four rounds,
  // each round being eight pair mixes and a copy; the last injection goes to FF.
  task automatic build_block(input bit mode);
    rec_t r;
    int   rnd = 0;
    r = active(mode); r.irw = 1'b1; r.pts = 1'b1; exp_q.push_back(r);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < 16; w++) begin
        if (w >= 13) begin
          r = active(mode); r.word = 4'(w); r.sub = 5'(s);
          r.x0 = 1'b1; r.x1 = 2'd1; r.skw = 1'b1; r.tw = exp_tweak(mode, s, w);
          exp_q.push_back(r);
        end
        r = active(mode); r.word = 4'(w); r.sub = 5'(s);
        r.x1 = 2'd2; r.orw = 16'd1 << w;
        exp_q.push_back(r);
      end
      if (s == NS - 1) break;
      r = active(mode); r.irw = 1'b1; exp_q.push_back(r);
      for (int k = 0; k < 4; k++) begin
        for (int p = 0; p < 8; p++) begin
          r = active(mode); r.word = 4'(p); r.rot = rot_tab[rnd % 8][p];
          r.orw = (16'd1 << pinv[2*p]) | (16'd1 << pinv[2*p+1]);
          r.y1  = 16'd1 << pinv[2*p+1];
          exp_q.push_back(r);
          mix_cnt++;
        end
        r = active(mode); r.irw = 1'b1; exp_q.push_back(r);
        rnd++;
      end
    end
    r = active(mode);
    if (mode) r.hrw = 1'b1; else r.krw = 1'b1;
    exp_q.push_back(r);
  endtask

  initial begin
    rec_t r;
    for (int i = 0; i < 16; i++) pinv[perm[i]] = 4'(i);

    mix_cnt = 0;
    build_block(1'b0);
    mix_blk0 = mix_cnt;
    build_block(1'b1);
    r = '0; r.done = 1'b1; exp_q.push_back(r);
    for (int i = 0; i < IDLE_TAIL; i++) exp_q.push_back('0);

    // Hand-computed pins on the model itself (index = cycle after start - 1).
    check_val("model_len", 64'(exp_q.size()), 64'(2283 + IDLE_TAIL));
    check_val("model_mix_blk0", 64'(mix_blk0), 64'd640);
    check_val("model_pinv1", 64'(pinv[1]), 64'd15);
    check_val("model_c1_load", {exp_q[0].irw, exp_q[0].pts, exp_q[0].hm}, 64'b110);
    check_val("model_c2_orw", 64'(exp_q[1].orw), 64'h0001);
    check_val("model_c71_tweak", exp_q[70].tw, MSG_T1);
    check_val("model_c75_tweak", exp_q[74].tw, 64'd1);
    check_val("model_c22_mix", {exp_q[21].rot, exp_q[21].orw, exp_q[21].y1},
              {6'd24, 16'h8001, 16'h8000});
    check_val("model_c1141_krw", 64'(exp_q[1140].krw), 64'd1);
    check_val("model_c1142_load", {exp_q[1141].pts, exp_q[1141].hm}, 64'b11);
    check_val("model_c2282_hrw", 64'(exp_q[2281].hrw), 64'd1);
    check_val("model_c2283_done", 64'(exp_q[2282].done), 64'd1);

    // Reset state, then a run aborted by reset in the middle of MIX.
    bus.start_i = 1'b0;
    #12;
    check_rec("reset_state", sample(), '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.start_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
      check_rec($sformatf("run1_cycle%0d", k), sample(), exp_q[k-1]);
    end
    rst_n = 1'b0;
    #1;
    check_rec("abort_mid_mix", sample(), '0);
    @(negedge clk);
    check_rec("abort_held", sample(), '0);
    rst_n = 1'b1;

    // Full run with start held high until the idle cycle after DONE.
    @(negedge clk); bus.start_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 2284) bus.start_i = 1'b0;
      check_rec($sformatf("run2_cycle%0d", k), sample(), exp_q[k-1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
